// File: rtl/seq_div_pkg.sv
// ============================================================================
// Module  : seq_div_pkg
// Brief   : Shared widths and FSM state encoding for the seq_div divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITER_W     = 4;
  localparam int REM_W      = DIVISOR_W + 1;

  // Counter value on the final quotient-bit iteration
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_div_div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division iteration (shift, trial
//           subtract, restore).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
  import seq_div_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W:0]   w_shifted;
  logic [REM_W-1:0] w_diff;

  // rem_in < divisor always holds, so the shifted value never exceeds 5 bits
  // and the difference only matters when it is non-negative.
  always_comb begin
    w_shifted = {rem_in, bit_in};
    w_diff    = w_shifted[REM_W-1:0] - {1'b0, divisor};
    q_bit     = (w_shifted >= {2'b00, divisor});
    rem_out   = q_bit ? w_diff : w_shifted[REM_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_div.sv
// ============================================================================
// Module  : seq_div
// Brief   : 8-by-4 bit unsigned sequential restoring divider, one quotient
//           bit per clock. Define SEQ_DIV_ERR_EN to add the err output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_div
  import seq_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
`ifdef SEQ_DIV_ERR_EN
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  err
`else
  output logic [DIVISOR_W-1:0]  remainder
`endif
);

  state_t                r_state;
  logic [REM_W-1:0]      r_rem;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [ITER_W-1:0]     r_cnt;

  logic [REM_W-1:0]      w_rem_next;
  logic                  w_q_bit;

  // r_shift feeds dividend bits out of the top and takes quotient bits in
  // at the bottom, so after eight steps it holds the full quotient.
  div_step u_step (
    .rem_in  (r_rem),
    .bit_in  (r_shift[DIVIDEND_W-1]),
    .divisor (r_divisor),
    .rem_out (w_rem_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_shift   <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIV_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_state   <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
`ifdef SEQ_DIV_ERR_EN
              err       <= 1'b1;
`endif
            end else begin
              r_state   <= CALC;
              busy      <= 1'b1;
              r_rem     <= '0;
              r_shift   <= dividend;
              r_divisor <= divisor;
              r_cnt     <= '0;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        CALC: begin
          r_rem   <= w_rem_next;
          r_shift <= {r_shift[DIVIDEND_W-2:0], w_q_bit};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {r_shift[DIVIDEND_W-2:0], w_q_bit};
            remainder <= w_rem_next[DIVISOR_W-1:0];
`ifdef SEQ_DIV_ERR_EN
            err       <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
